// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - snapshot processor result matrix and stream it row-major; optional ROW_SUM_EN adds a checksum word per row
module matrix_result_streamer #(
  parameter int WIDTH     = 4,
  parameter int WIDTH_BIT = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      done,
  input  logic [WIDTH*WIDTH*32-1:0] result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_data,
  output logic [WIDTH_BIT-1:0]      out_row,
  output logic [WIDTH_BIT-1:0]      out_col,
  output logic                      out_last,
  output logic                      out_is_sum,
  output logic                      busy,
  output logic                      overflow,
  output logic [7:0]                frame_cnt
);

  localparam int NELEM = WIDTH * WIDTH;
  localparam logic [WIDTH_BIT-1:0] IDX_MAX = WIDTH_BIT'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_SUM
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_done_q;
  logic [WIDTH_BIT-1:0]   r_row;
  logic [WIDTH_BIT-1:0]   r_col;
  logic [WIDTH_BIT-1:0]   w_row_nxt;
  logic [WIDTH_BIT-1:0]   w_col_nxt;
  logic                   r_overflow;
  logic [7:0]             r_frame_cnt;
  logic [31:0]            r_buf [0:NELEM-1];
  logic                   w_trig;
  logic                   w_hs;
  logic                   w_load;
  logic                   w_drop;
  logic                   w_frame_done;
  logic [2*WIDTH_BIT-1:0] w_idx;

  // A capture is requested only on the rising edge of done
  assign w_trig = done & ~r_done_q;
  assign w_hs   = out_valid & out_ready;
  // Row-major linear address into the snapshot (WIDTH is a power of 2)
  assign w_idx  = {r_row, r_col};

`ifdef ROW_SUM_EN
  logic [31:0] r_sum     [0:WIDTH-1];
  logic [31:0] w_row_sum [0:WIDTH-1];

  // Row checksums computed straight from the incoming matrix so they land with the snapshot
  always_comb begin : row_sum_calc
    logic [31:0] v_acc;
    v_acc = '0;
    for (int r = 0; r < WIDTH; r++) begin
      v_acc = '0;
      for (int c = 0; c < WIDTH; c++) begin
        v_acc = v_acc + result[(NELEM-1-(r*WIDTH+c))*32 +: 32];
      end
      w_row_sum[r] = v_acc;
    end
  end
`endif

  // Next-state, index advance, frame bookkeeping and output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_frame_done = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    out_is_sum   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_load      = 1'b1;
          w_state_nxt = S_STREAM;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = r_buf[w_idx];
`ifndef ROW_SUM_EN
        out_last  = (r_row == IDX_MAX) && (r_col == IDX_MAX);
`endif
        if (w_hs) begin
          if (r_col == IDX_MAX) begin
`ifdef ROW_SUM_EN
            // Column index stays at the last column while the row sum is presented
            w_state_nxt = S_SUM;
`else
            w_col_nxt = '0;
            w_row_nxt = r_row + WIDTH_BIT'(1);
`endif
          end else begin
            w_col_nxt = r_col + WIDTH_BIT'(1);
          end
        end
      end
`ifdef ROW_SUM_EN
      S_SUM: begin
        out_valid  = 1'b1;
        out_data   = r_sum[r_row];
        out_is_sum = 1'b1;
        out_last   = (r_row == IDX_MAX);
        if (w_hs) begin
          w_state_nxt = S_STREAM;
          w_col_nxt   = '0;
          w_row_nxt   = r_row + WIDTH_BIT'(1);
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    // Frame end: either reload seamlessly from a coincident trigger or go idle.
    // Any other trigger while a frame is held is dropped.
    if (w_hs && out_last) begin
      w_frame_done = 1'b1;
      if (w_trig) begin
        w_load      = 1'b1;
        w_state_nxt = S_STREAM;
        w_row_nxt   = '0;
        w_col_nxt   = '0;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else if (w_trig && (r_state != S_IDLE)) begin
      w_drop = 1'b1;
    end
  end

  // Control state, indices, done edge detector and status counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_done_q    <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_done_q <= done;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // Snapshot storage; contents are don't-care out of reset so it carries no reset term
  always_ff @(posedge CLK) begin
    if (w_load) begin
      for (int i = 0; i < NELEM; i++) begin
        r_buf[i] <= result[(NELEM-1-i)*32 +: 32];
      end
`ifdef ROW_SUM_EN
      for (int r = 0; r < WIDTH; r++) begin
        r_sum[r] <= w_row_sum[r];
      end
`endif
    end
  end

  assign out_row   = r_row;
  assign out_col   = r_col;
  assign busy      = out_valid;
  assign overflow  = r_overflow;
  assign frame_cnt = r_frame_cnt;

endmodule
